// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - op encodings MD_MULT .. MD_MSUBU (10-15 reserved)
//   - FSM state encoding
//   - per-op classification masks, indexed by the 4-bit op code
package muldiv_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  // Classification masks: bit n is set when op n belongs to the class.
  localparam logic [15:0] MD_MUL_MASK    = 16'b0000_0000_0000_0011; // MULT, MULTU
  localparam logic [15:0] MD_MACC_MASK   = 16'b0000_0011_1100_0000; // MADD..MSUBU
  localparam logic [15:0] MD_DIV_MASK    = 16'b0000_0000_0000_1100; // DIV, DIVU
  localparam logic [15:0] MD_SIGNED_MASK = 16'b0000_0001_0100_0101; // MULT, DIV, MADD, MSUB
  localparam logic [15:0] MD_SUB_MASK    = 16'b0000_0011_0000_0000; // MSUB, MSUBU

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative restoring unsigned divider, one quotient bit
// per cycle, WIDTH iterations. The first iteration is performed on the
// load edge itself, so valid is high in the WIDTH-th cycle after load and
// the consumer can commit the result on the following edge.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                capture dividend/divisor and start
//   abort               stop the running division (result discarded)
//   dividend, divisor   unsigned magnitudes
//   quotient, remainder results, meaningful while valid=1
//   valid               last iteration done, results stable
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int CNTW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_reg, quo_reg, dsr_reg;
  logic [WIDTH-1:0] rem_src, quo_src, dsr_src;
  logic [CNTW-1:0]  cnt_reg;
  logic             run_reg;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // On the load edge the step works directly on the incoming operands.
  always_comb begin
    rem_src = load ? '0       : rem_reg;
    quo_src = load ? dividend : quo_reg;
    dsr_src = load ? divisor  : dsr_reg;
    shifted = {rem_src, quo_src[WIDTH-1]};
    ge      = shifted >= {1'b0, dsr_src};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dsr_reg <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (abort) begin
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (load || (run_reg && cnt_reg != '0)) begin
      // Partial remainder is always below the divisor, so it fits WIDTH bits.
      rem_reg <= WIDTH'(ge ? shifted - {1'b0, dsr_src} : shifted);
      quo_reg <= {quo_src[WIDTH-2:0], ge};
      dsr_reg <= dsr_src;
      cnt_reg <= load ? CNTW'(WIDTH - 1) : cnt_reg - CNTW'(1);
      run_reg <= 1'b1;
    end else if (run_reg) begin
      run_reg <= 1'b0;
    end
  end

  assign valid     = run_reg && (cnt_reg == '0);
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Multiplies latch the full 2*WIDTH product at start and commit after
// MUL_CYCLES; divides run the restoring divider on operand magnitudes and
// fix up signs and special cases at commit. A flush kills a starting or
// in-flight op without touching HI/LO.
// Optional feature macro: MULDIV_MACC_EN enables MADD/MADDU/MSUB/MSUBU
// (ops 6-9); without it those ops are ignored and no accumulate adder exists.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start, op, a, b  request, op code, rs / rt operands
//   flush            cancel the starting or in-flight op
//   busy             operation in progress
//   done             one-cycle pulse when new HI/LO become visible
//   hi, lo           architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e          state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg, a_reg, b_reg;
  logic               busy_reg, done_reg, div_signed_reg;

  logic               take, is_mul, is_macc, is_div, op_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_result;
  logic [WIDTH-1:0]   a_mag, b_mag, div_quo, div_rem, q_fix, r_fix;
  logic               div_valid;

  assign take      = start && !flush && (state_reg == ST_IDLE);
  assign is_mul    = MD_MUL_MASK[op];
  assign is_div    = MD_DIV_MASK[op];
  assign op_signed = MD_SIGNED_MASK[op];

  // Product is formed at start; sign extension to 2*WIDTH makes the
  // modulo-2^(2*WIDTH) product correct for both signed and unsigned ops.
  assign ext_a   = op_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign ext_b   = op_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign product = ext_a * ext_b;

  assign a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (op_signed && b[WIDTH-1]) ? -b : b;

  muldiv_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .reset     (reset),
    .load      (take && is_div),
    .abort     (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  assign q_fix = (div_signed_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])) ? -div_quo : div_quo;
  assign r_fix = (div_signed_reg && a_reg[WIDTH-1]) ? -div_rem : div_rem;

`ifdef MULDIV_MACC_EN
  logic               acc_reg, sub_reg;
  logic [2*WIDTH-1:0] hilo;

  assign is_macc = MD_MACC_MASK[op];
  assign hilo    = {hi_reg, lo_reg};

  // Accumulation uses HI/LO as they stand at completion.
  always_comb begin
    mul_result = prod_reg;
    if (acc_reg) begin
      mul_result = sub_reg ? hilo - prod_reg : hilo + prod_reg;
    end
  end
`else
  assign is_macc    = 1'b0;
  assign mul_result = prod_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      prod_reg       <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      div_signed_reg <= 1'b0;
`ifdef MULDIV_MACC_EN
      acc_reg        <= 1'b0;
      sub_reg        <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (take) begin
            if (is_mul || is_macc) begin
              state_reg <= ST_MUL;
              busy_reg  <= 1'b1;
              cnt_reg   <= CW'(MUL_CYCLES);
              prod_reg  <= product;
`ifdef MULDIV_MACC_EN
              acc_reg   <= is_macc;
              sub_reg   <= MD_SUB_MASK[op];
`endif
            end else if (is_div) begin
              state_reg      <= ST_DIV;
              busy_reg       <= 1'b1;
              a_reg          <= a;
              b_reg          <= b;
              div_signed_reg <= op_signed;
            end else if (op == MD_MTHI) begin
              hi_reg <= a;
            end else if (op == MD_MTLO) begin
              lo_reg <= a;
            end
          end
        end
        ST_MUL: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (flush) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == CW'(1)) begin
            {hi_reg, lo_reg} <= mul_result;
            done_reg         <= 1'b1;
            state_reg        <= ST_IDLE;
            busy_reg         <= 1'b0;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (div_valid) begin
            if (b_reg == '0) begin
              lo_reg <= '1;
              hi_reg <= a_reg;
            end else if (div_signed_reg && a_reg == MIN_VAL && b_reg == '1) begin
              lo_reg <= MIN_VAL;
              hi_reg <= '0;
            end else begin
              lo_reg <= q_fix;
              hi_reg <= r_fix;
            end
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit
// (WIDTH=32, MUL_CYCLES=5) against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  localparam int MC = 5;
`ifdef MULDIV_MACC_EN
  localparam bit MACC = 1'b1;
`else
  localparam bit MACC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] model_hl;

  muldiv_unit #(.WIDTH(32), .MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference: new {hi,lo} from op, operands and current {hi,lo}.
  function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] hl);
    longint      sx, sy, sq, sr;
    logic [63:0] ps, pu, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ps = sx * sy;
    pu = {32'd0, x} * {32'd0, y};
    case (o)
      4'd0: return ps;
      4'd1: return pu;
      4'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      4'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        uq = {32'd0, x} / {32'd0, y};
        ur = {32'd0, x} % {32'd0, y};
        return {ur[31:0], uq[31:0]};
      end
      4'd4: return {x, hl[31:0]};
      4'd5: return {hl[63:32], x};
      4'd6: return MACC ? hl + ps : hl;
      4'd7: return MACC ? hl + pu : hl;
      4'd8: return MACC ? hl - ps : hl;
      4'd9: return MACC ? hl - pu : hl;
      default: return hl;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] o);
    if (o <= 4'd1) return MC;
    if (o == 4'd2 || o == 4'd3) return 32;
    if (o >= 4'd6 && o <= 4'd9 && MACC) return MC;
    return 0;
  endfunction

  // Drive one start cycle; returns #1 after the sampling edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic fl);
    op = o; a = x; b = y; start = 1'b1; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    $display("txn op=%0d a=%08h b=%08h flush=%0b busy=%0b hi=%08h lo=%08h",
             o, x, y, fl, busy, hi, lo);
  endtask

  // Count edges while busy (bounded); ends in the cycle after busy drops.
  task automatic wait_done(output int nb, output bit dn);
    nb = 0;
    while (busy === 1'b1 && nb < 200) begin
      @(posedge clk); #1;
      nb++;
    end
    dn = done;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int nb, output bit dn);
    issue(o, x, y, 1'b0);
    wait_done(nb, dn);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b0;
    model_hl = '0;
  endtask

  task automatic test_mult();
    int nb; bit dn;
    run_op(4'd0, 32'hFFFF_FFFE, 32'd3, nb, dn);
    n_vec++; if (nb !== MC) begin n_err++; $display("FAIL mult_busy got %0d want %0d", nb, MC); end
    n_vec++; if (dn !== 1'b1) begin n_err++; $display("FAIL mult_done got %b want 1", dn); end
    n_vec++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_err++; $display("FAIL mult_hilo got %h%h want FFFFFFFFFFFFFFFA", hi, lo); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse got %b want 0", done); end
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, nb, dn);
    n_vec++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin n_err++; $display("FAIL multu_hilo got %h%h want 00000002FFFFFFFA", hi, lo); end
    model_hl = {hi, lo};
  endtask

  task automatic test_div();
    int nb; bit dn;
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, nb, dn);
    n_vec++; if (nb !== 32) begin n_err++; $display("FAIL div_busy got %0d want 32", nb); end
    n_vec++; if (dn !== 1'b1) begin n_err++; $display("FAIL div_done got %b want 1", dn); end
    n_vec++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_hilo got %h%h want FFFFFFFFFFFFFFFD", hi, lo); end
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb, dn);
    n_vec++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL div_minneg1 got %h%h want 0000000080000000", hi, lo); end
    run_op(4'd3, 32'h0000_1234, 32'd0, nb, dn);
    n_vec++; if ({hi, lo} !== 64'h0000_1234_FFFF_FFFF) begin n_err++; $display("FAIL divu_zero got %h%h want 00001234FFFFFFFF", hi, lo); end
    model_hl = {hi, lo};
  endtask

  task automatic test_flush();
    int nb; bit dn;
    run_op(4'd4, 32'h11, 32'd0, nb, dn);
    run_op(4'd5, 32'h22, 32'd0, nb, dn);
    n_vec++; if ({hi, lo} !== 64'h0000_0011_0000_0022) begin n_err++; $display("FAIL mthi_mtlo got %h%h want 0000001100000022", hi, lo); end
    model_hl = 64'h0000_0011_0000_0022;
    issue(4'd0, 32'd7, 32'd9, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL flush_done got %b want 0", done); end
    n_vec++; if ({hi, lo} !== model_hl) begin n_err++; $display("FAIL flush_hilo got %h%h want %h", hi, lo, model_hl); end
    wait_done(nb, dn);
    n_vec++; if (dn !== 1'b0) begin n_err++; $display("FAIL flush_late_done got %b want 0", dn); end
    issue(4'd4, 32'h55, 32'd0, 1'b1);
    n_vec++; if (hi !== 32'h11) begin n_err++; $display("FAIL start_flush_mthi got %h want 11", hi); end
    issue(4'd2, 32'd100, 32'd7, 1'b1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_flush_div got %b want 0", busy); end
    // flush coinciding with the completing edge of a divide
    issue(4'd3, 32'd1000, 32'd7, 1'b0);
    repeat (31) begin @(posedge clk); #1; end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL div_cycle32_busy got %b want 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL flush_complete_done got %b want 0", done); end
    n_vec++; if ({hi, lo} !== model_hl) begin n_err++; $display("FAIL flush_complete_hilo got %h%h want %h", hi, lo, model_hl); end
  endtask

  task automatic test_macc();
    int nb; bit dn;
    run_op(4'd4, 32'd0, 32'd0, nb, dn);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd0, nb, dn);
    model_hl = 64'h0000_0000_FFFF_FFFF;
`ifdef MULDIV_MACC_EN
    run_op(4'd7, 32'd1, 32'd1, nb, dn);
    n_vec++; if (nb !== MC) begin n_err++; $display("FAIL maddu_busy got %0d want %0d", nb, MC); end
    n_vec++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL maddu_hilo got %h%h want 0000000100000000", hi, lo); end
    run_op(4'd8, 32'd1, 32'd1, nb, dn);
    n_vec++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL msub_hilo got %h%h want 00000000FFFFFFFF", hi, lo); end
`else
    run_op(4'd6, 32'd1, 32'd1, nb, dn);
    n_vec++; if (nb !== 0) begin n_err++; $display("FAIL op6_busy got %0d want 0", nb); end
    n_vec++; if ({hi, lo} !== model_hl) begin n_err++; $display("FAIL op6_hilo got %h%h want %h", hi, lo, model_hl); end
`endif
    model_hl = {hi, lo};
  endtask

  task automatic test_reset_mid_div();
    int nb; bit dn;
    run_op(4'd4, 32'hAAAA_5555, 32'd0, nb, dn);
    issue(4'd3, 32'hFFFF_0000, 32'd13, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_div_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_div_done got %b want 0", done); end
    n_vec++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL rst_div_hilo got %h%h want 0", hi, lo); end
    model_hl = '0;
  endtask

  task automatic test_start_while_busy();
    int nb; bit dn;
    logic [31:0] x, y;
    logic [63:0] exp_hl;
    x = $urandom; y = $urandom;
    exp_hl = ref_op(4'd0, x, y, model_hl);
    issue(4'd0, x, y, 1'b0);
    op = 4'd4; a = 32'hDEAD_BEEF; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    op = 4'd2; a = 32'd77;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(nb, dn);
    n_vec++; if (nb + 2 !== MC) begin n_err++; $display("FAIL swb_busy got %0d want %0d", nb + 2, MC); end
    n_vec++; if ({hi, lo} !== exp_hl) begin n_err++; $display("FAIL swb_hilo got %h%h want %h", hi, lo, exp_hl); end
    model_hl = exp_hl;
  endtask

  task automatic test_back_to_back();
    int nb; bit dn;
    logic [3:0]  seq_op [4] = '{4'd1, 4'd2, 4'd0, 4'd3};
    logic [31:0] x, y;
    logic [63:0] exp_hl;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom_range(1, 1000);
      exp_hl = ref_op(seq_op[i], x, y, model_hl);
      run_op(seq_op[i], x, y, nb, dn);
      n_vec++; if (nb !== ref_lat(seq_op[i])) begin n_err++; $display("FAIL b2b_busy op=%0d got %0d want %0d", seq_op[i], nb, ref_lat(seq_op[i])); end
      n_vec++; if ({hi, lo} !== exp_hl) begin n_err++; $display("FAIL b2b_hilo op=%0d got %h%h want %h", seq_op[i], hi, lo, exp_hl); end
      model_hl = exp_hl;
    end
  endtask

  task automatic test_random();
    int nb; bit dn;
    logic [3:0]  o;
    logic [31:0] x, y;
    logic [63:0] exp_hl;
    int          exp_len;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 13));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 1000); y = $urandom_range(1, 20); end
        3: y = -($urandom_range(1, 20));
        default: ;
      endcase
      exp_hl  = ref_op(o, x, y, model_hl);
      exp_len = ref_lat(o);
      run_op(o, x, y, nb, dn);
      n_vec++; if (nb !== exp_len) begin n_err++; $display("FAIL rnd_busy op=%0d got %0d want %0d", o, nb, exp_len); end
      n_vec++; if (dn !== (exp_len != 0)) begin n_err++; $display("FAIL rnd_done op=%0d got %b want %b", o, dn, exp_len != 0); end
      n_vec++; if ({hi, lo} !== exp_hl) begin n_err++; $display("FAIL rnd_hilo op=%0d a=%h b=%h got %h%h want %h", o, x, y, hi, lo, exp_hl); end
      model_hl = exp_hl;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd0; a = '0; b = '0;
    model_hl = '0;
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_macc();
    test_reset_mid_div();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the Execution stage. It generalises the fixed 32-bit multiplier with width and latency parameters. It adds an iterative restoring divider, pipeline-flush cancellation, and optional multiply-accumulate. The Execution stage starts operations and reads HI/LO; the hazard unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4 and even.
- `MUL_CYCLES`, 5: busy cycles of a multiply or accumulate; must be ≥ 1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; op and operands are sampled on this edge.
- `op`  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10–15 reserved.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / move source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `flush`  in  1  kills the uncommitted in-flight or starting op.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse when new HI/LO values become visible.
- `hi`, `lo`  out  WIDTH  architectural HI and LO registers.

## Operation
- On reset: `busy`=0, `done`=0, `hi`=0, `lo`=0, FSM IDLE, counter 0, divider cleared.
- FSM states are IDLE, MUL and DIV.
- IDLE + `start` + ~`flush`:
  - Ops 0, 1, 6–9 go to MUL. Counter loads `MUL_CYCLES`. The 2·WIDTH product (signed for 0/6/8, unsigned for 1/7/9) is latched.
  - Ops 2, 3 go to DIV. The divider loads and runs WIDTH iterations.
  - Op 4 writes `hi`←`a` and op 5 writes `lo`←`a` on the same edge. The FSM stays in IDLE, `busy` stays 0 and `done` is not pulsed.
  - Reserved ops are ignored.
- MUL: the counter decrements each cycle. When it reaches 1, the next edge writes the result, returns to IDLE and pulses `done`.
  - MULT/MULTU: {hi,lo} ← product.
  - MADD/MADDU: {hi,lo} ← {hi,lo} + product, modulo 2^(2·WIDTH), using HI/LO at completion.
  - MSUB/MSUBU: {hi,lo} ← {hi,lo} − product, modulo 2^(2·WIDTH).
- DIV uses restoring, one quotient bit per cycle, on magnitudes.
  - Signs are fixed up at completion: quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
  - Completion writes `lo`←quotient and `hi`←remainder.
- Division by zero, signed or unsigned: `lo`←all ones, `hi`←`a`.
- Signed MIN / −1: `lo`←MIN, `hi`←0.
- `start` while `busy`=1 is ignored, including MTHI/MTLO; the hazard unit must stall.
- `flush`:
  - Flush with `start` in the same cycle: the start is ignored.
  - Flush while busy: the next edge returns to IDLE, `busy`=0, no `done`, and HI/LO keep their pre-operation values.
- HI/LO change only at completion, on MTHI/MTLO, or on reset. During `busy` they hold old values.

## Timing
- Start sampled at edge E. `busy`=1 for L cycles after E, with L = `MUL_CYCLES` (multiply) or WIDTH (divide).
- New HI/LO become visible in cycle L+1 after E, with `done`=1 and `busy`=0.
- A new `start` is accepted in that same cycle.
- Back-to-back operation has no dead cycle.
- MTHI/MTLO take effect in the cycle after E.
- Reset wins over everything, including mid-operation; there is no `done` and HI/LO clear.
- Flush wins over completion: if flush arrives on the completing edge, nothing is written.

## Configuration
- `MULDIV_MACC_EN` defined: ops 6–9 are implemented as above.
- Undefined:
  - Ops 6–9 are treated as reserved and ignored (no busy, no write).
  - The accumulate adder is not built.

## Structure
- `muldiv_pkg` holds:
  - op encodings `MD_MULT`…`MD_MSUBU`;
  - FSM state encodings;
  - a `MD_IS_MUL(op)`-style classification constant set.
- Sub-module `muldiv_divider`: iterative restoring unsigned divider with `load`/`abort` inputs and quotient/remainder/`valid` outputs, run for WIDTH cycles.
- Sign pre-processing, post-processing and special-case handling live in `muldiv_unit`.

## Test plan
All scenarios use WIDTH=32, MUL_CYCLES=5.
- MULT a=0xFFFFFFFE, b=3 -> `busy` for 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, `done` for 1 cycle. MULTU with the same operands -> `hi`=0x2, `lo`=0xFFFFFFFA.
- DIV a=0xFFFFFFF9, b=2 -> `busy` for 32 cycles, then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU a=0x1234, b=0 -> `lo`=0xFFFFFFFF, `hi`=0x1234.
- MTHI 0x11 then MTLO 0x22, then MULT 7×9 with `flush` in its 3rd busy cycle -> `busy`=0 the next cycle, no `done`, `hi`=0x11, `lo`=0x22. Then `start` + `flush` together -> ignored.
- With `MULDIV_MACC_EN`: preload `hi`=0, `lo`=0xFFFFFFFF, then MADDU 1×1 -> `hi`=1, `lo`=0. MSUB 1×1 -> `hi`=0, `lo`=0xFFFFFFFF. Without the macro: op 6 -> no busy, HI/LO unchanged.
- `reset` at cycle 10 of a DIV -> next cycle `busy`=0, `hi`=`lo`=0, no `done`. A `start` while busy -> ignored, result of the first op unaffected.
